regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined RV32 core; next generation of the single-issue 2R/1W file.
- Configurable data width, depth, read-port count and write-port count.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard (set at issue, cleared at writeback) so decode can stall on RAW hazards without a separate unit.
- Sits between decode (reads and issue) and writeback (writes).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard for RAW hazard stalls in the decode stage.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs_r     [NREGS];
    logic [XLEN-1:0]  regs_nxt_s [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [NWR-1:0]   wr_ok_s;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    // Per-port write qualification: writes to a hardwired zero register are dropped
    always_comb begin
        wr_ok_s = '0;
        for (int k = 0; k < NWR; k++) begin
            wr_ok_s[k] = wr_en[k] & ~is_zero_reg(wr_addr[k*AW +: AW]);
        end
    end

    // Next-state storage and scoreboard; later ports override earlier ones,
    // and an issue is applied after writeback clears so the new producer wins
    always_comb begin
        busy_nxt_s = busy_r;
        for (int r = 0; r < NREGS; r++) begin
            regs_nxt_s[r] = regs_r[r];
            for (int k = 0; k < NWR; k++) begin
                regs_nxt_s[r] = (wr_ok_s[k] && (wr_addr[k*AW +: AW] == AW'(r)))
                              ? wr_data[k*XLEN +: XLEN] : regs_nxt_s[r];
                busy_nxt_s[r] = (wr_ok_s[k] && (wr_addr[k*AW +: AW] == AW'(r)))
                              ? 1'b0 : busy_nxt_s[r];
            end
            busy_nxt_s[r] = (iss_en && !is_zero_reg(iss_addr) && (iss_addr == AW'(r)))
                          ? 1'b1 : busy_nxt_s[r];
        end
    end

    // Storage and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
            busy_r <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= regs_nxt_s[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            hit;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            addr = rd_addr[i*AW +: AW];
            data = regs_r[addr];
            hit  = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if ((BYPASS != 0) && wr_en[k] && (wr_addr[k*AW +: AW] == addr)) begin
                    data = wr_data[k*XLEN +: XLEN];
                    hit  = 1'b1;
                end else begin
                    hit  = hit;
                end
            end
            rd_data[i*XLEN +: XLEN] = is_zero_reg(addr) ? {XLEN{1'b0}} : data;
            rd_busy[i]              = ~is_zero_reg(addr) & busy_r[addr] & ~hit;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing 2-write instance, one
// non-bypassing instance and a wide 16-entry 3-read instance without zero reg.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance A: NWR=2, BYPASS=1, ZERO_REG=1
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_iss_en;
    logic [4:0]  a_iss_addr;
    logic [31:0] a_busy_vec;

    // Instance B: NWR=1, BYPASS=0
    logic [9:0]  b_rd_addr;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [0:0]  b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_iss_en;
    logic [4:0]  b_iss_addr;
    logic [31:0] b_busy_vec;

    // Instance C: NREGS=16, XLEN=64, NRD=3, ZERO_REG=0
    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic [0:0]   c_wr_en;
    logic [3:0]   c_wr_addr;
    logic [63:0]  c_wr_data;
    logic         c_iss_en;
    logic [3:0]   c_iss_addr;
    logic [15:0]  c_busy_vec;

    regfile_mp #(.NWR(2), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.NWR(1), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .busy_vec(b_busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1), .ZERO_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .busy_vec(c_busy_vec)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_wr_en = 2'b00; a_wr_addr = 10'd0; a_wr_data = 64'd0; a_iss_en = 1'b0; a_iss_addr = 5'd0;
        b_wr_en = 1'b0;  b_wr_addr = 5'd0;  b_wr_data = 32'd0; b_iss_en = 1'b0; b_iss_addr = 5'd0;
        c_wr_en = 1'b0;  c_wr_addr = 4'd0;  c_wr_data = 64'd0; c_iss_en = 1'b0; c_iss_addr = 4'd0;
    endtask

    initial begin
        idle();
        a_rd_addr = {5'd3, 5'd5};
        b_rd_addr = {5'd3, 5'd5};
        c_rd_addr = {4'd1, 4'd2, 4'd0};
        rst_n = 1'b0;
        #2;
        check("reset_a_rd", a_rd_data, 64'd0);
        check("reset_a_busy", {62'd0, a_rd_busy}, 64'd0);
        check("reset_a_vec", {32'd0, a_busy_vec}, 64'd0);
        check("reset_c_rd0", c_rd_data[63:0], 64'd0);

        @(negedge clk); rst_n = 1'b1;

        // Basic write then read on both ports
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'd0, 32'h1234_5678};
        @(negedge clk); idle(); a_rd_addr = {5'd3, 5'd3};
        #1;
        check("write_x3_p0", {32'd0, a_rd_data[31:0]}, 64'h1234_5678);
        check("write_x3_p1", {32'd0, a_rd_data[63:32]}, 64'h1234_5678);

        // x0 writes are dropped, same cycle and after
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'd0, 32'hFFFF_FFFF};
        a_rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_bypass", a_rd_data, 64'd0);
        @(negedge clk); idle(); a_rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_stored", a_rd_data, 64'd0);

        // Bypass vs no bypass
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd10}; a_wr_data = {32'd0, 32'hA5A5_A5A5};
        a_rd_addr = {5'd3, 5'd10};
        b_wr_en = 1'b1; b_wr_addr = 5'd10; b_wr_data = 32'hA5A5_A5A5;
        b_rd_addr = {5'd0, 5'd10};
        #1;
        check("bypass_on", {32'd0, a_rd_data[31:0]}, 64'hA5A5_A5A5);
        check("bypass_other_port", {32'd0, a_rd_data[63:32]}, 64'h1234_5678);
        check("bypass_off_old", {32'd0, b_rd_data[31:0]}, 64'd0);
        @(negedge clk); idle(); b_rd_addr = {5'd0, 5'd10};
        #1;
        check("bypass_off_next", {32'd0, b_rd_data[31:0]}, 64'hA5A5_A5A5);

        // Two ports write x4: port 1 wins
        a_wr_en = 2'b11; a_wr_addr = {5'd4, 5'd4}; a_wr_data = {32'h2, 32'h1};
        a_rd_addr = {5'd4, 5'd4};
        #1;
        check("conflict_bypass", {32'd0, a_rd_data[31:0]}, 64'h2);
        @(negedge clk); idle(); a_rd_addr = {5'd4, 5'd4};
        #1;
        check("conflict_stored", {32'd0, a_rd_data[63:32]}, 64'h2);

        // Scoreboard: issue x6, then writeback while reading
        a_iss_en = 1'b1; a_iss_addr = 5'd6; a_rd_addr = {5'd6, 5'd6};
        b_iss_en = 1'b1; b_iss_addr = 5'd6;
        #1;
        check("issue_same_cycle", {62'd0, a_rd_busy}, 64'd0);
        @(negedge clk); idle(); a_rd_addr = {5'd6, 5'd6};
        #1;
        check("issue_rd_busy", {62'd0, a_rd_busy}, 64'h3);
        check("issue_vec", {32'd0, a_busy_vec}, 64'h40);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd6}; a_wr_data = {32'd0, 32'h6666};
        b_wr_en = 1'b1; b_wr_addr = 5'd6; b_wr_data = 32'h6666; b_rd_addr = {5'd6, 5'd6};
        #1;
        check("wb_rd_busy_bypass", {62'd0, a_rd_busy}, 64'd0);
        check("wb_rd_data_bypass", {32'd0, a_rd_data[31:0]}, 64'h6666);
        check("wb_rd_busy_nobypass", {62'd0, b_rd_busy}, 64'h3);
        check("wb_rd_data_nobypass", {32'd0, b_rd_data[31:0]}, 64'd0);
        @(negedge clk); idle(); a_rd_addr = {5'd6, 5'd6}; b_rd_addr = {5'd6, 5'd6};
        #1;
        check("wb_clear_a", {32'd0, a_busy_vec}, 64'd0);
        check("wb_clear_b", {32'd0, b_busy_vec}, 64'd0);
        check("wb_data_b", {32'd0, b_rd_data[63:32]}, 64'h6666);

        // Issue and writeback of x6 together keeps it busy
        a_iss_en = 1'b1; a_iss_addr = 5'd6;
        @(negedge clk); idle();
        a_iss_en = 1'b1; a_iss_addr = 5'd6;
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd6}; a_wr_data = {32'd0, 32'h7777};
        @(negedge clk); idle(); a_rd_addr = {5'd6, 5'd6};
        #1;
        check("iss_wb_vec", {32'd0, a_busy_vec}, 64'h40);
        check("iss_wb_data", {32'd0, a_rd_data[31:0]}, 64'h7777);
        check("iss_wb_rd_busy", {62'd0, a_rd_busy}, 64'h3);

        // Issue to x0 ignored
        a_iss_en = 1'b1; a_iss_addr = 5'd0;
        @(negedge clk); idle(); a_rd_addr = {5'd0, 5'd0};
        #1;
        check("iss_x0_vec", {32'd0, a_busy_vec}, 64'h40);
        check("iss_x0_rd_busy", {62'd0, a_rd_busy}, 64'd0);

        // Wide instance, ordinary x0 storage, three independent ports
        c_wr_en = 1'b1; c_wr_addr = 4'd0; c_wr_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); c_wr_addr = 4'd5; c_wr_data = 64'hFEDC_BA98_7654_3210;
        @(negedge clk); c_wr_addr = 4'd15; c_wr_data = 64'h5555_AAAA_0000_FFFF;
        @(negedge clk); idle(); c_rd_addr = {4'd15, 4'd5, 4'd0};
        #1;
        check("c_p0_x0", c_rd_data[63:0], 64'h0123_4567_89AB_CDEF);
        check("c_p1_x5", c_rd_data[127:64], 64'hFEDC_BA98_7654_3210);
        check("c_p2_x15", c_rd_data[191:128], 64'h5555_AAAA_0000_FFFF);
        c_rd_addr = {4'd0, 4'd9, 4'd5};
        #1;
        check("c_p0_x5", c_rd_data[63:0], 64'hFEDC_BA98_7654_3210);
        check("c_p1_x9", c_rd_data[127:64], 64'd0);
        check("c_p2_x0", c_rd_data[191:128], 64'h0123_4567_89AB_CDEF);
        c_iss_en = 1'b1; c_iss_addr = 4'd0;
        @(negedge clk); idle(); c_rd_addr = {4'd0, 4'd9, 4'd5};
        #1;
        check("c_iss_x0_vec", {48'd0, c_busy_vec}, 64'h1);
        check("c_iss_x0_busy", {61'd0, c_rd_busy}, 64'h4);

        // Asynchronous reset mid-cycle
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'd0, 32'hDEAD_BEEF};
        a_iss_en = 1'b1; a_iss_addr = 5'd7;
        @(negedge clk); idle(); a_rd_addr = {5'd7, 5'd5};
        #1;
        check("pre_reset_data", {32'd0, a_rd_data[31:0]}, 64'hDEAD_BEEF);
        check("pre_reset_vec", {32'd0, a_busy_vec}, 64'hC0);
        check("pre_reset_busy", {62'd0, a_rd_busy}, 64'h2);
        rst_n = 1'b0;
        #1;
        check("async_reset_data", a_rd_data, 64'd0);
        check("async_reset_vec", {32'd0, a_busy_vec}, 64'd0);
        check("async_reset_busy", {62'd0, a_rd_busy}, 64'd0);
        check("async_reset_c", c_rd_data[191:128], 64'd0);

        // Writes and issues during reset are discarded
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'd0, 32'h1234};
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        @(negedge clk); idle(); rst_n = 1'b1; a_rd_addr = {5'd9, 5'd9};
        #1;
        check("reset_drop_data", a_rd_data, 64'd0);
        check("reset_drop_vec", {32'd0, a_busy_vec}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
